// File: rtl/pipeline_hazard_ctrl_pkg.sv
// pipeline_hazard_ctrl_pkg: register names, hazard FSM states and source-match helper
// shared by the hazard controller and its load-use comparator.
package pipeline_hazard_ctrl_pkg;

   typedef enum logic [4:0] {
      zero, ra, sp, gp, tp, t0, t1, t2, s0, s1, a0, a1, a2, a3, a4, a5,
      a6, a7, s2, s3, s4, s5, s6, s7, s8, s9, s10, s11, t3, t4, t5, t6
   } regName_t;

   typedef enum logic [1:0] {RUN, MEM_WAIT, TIMEOUT} hazard_state_t;

   function automatic logic src_match(input logic uses, input regName_t rs, input regName_t rd);
      return uses && rs == rd;
   endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_load_use_detect.sv
// load_use_detect: flags an ID-stage read of a register still being loaded in EX;
// x0 never hazards since it is hardwired to zero.
module load_use_detect
   import pipeline_hazard_ctrl_pkg::*;
(
   input  logic     memRead_EX,
   input  regName_t rd_EX,
   input  regName_t rs1_ID,
   input  regName_t rs2_ID,
   input  logic     usesRs1_ID,
   input  logic     usesRs2_ID,
   output logic     load_use
);

   assign load_use = memRead_EX && rd_EX != zero &&
                     (src_match(usesRs1_ID, rs1_ID, rd_EX) || src_match(usesRs2_ID, rs2_ID, rd_EX));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: pipeline-register enable/flush/bubble control for load-use stalls,
// taken-branch squashes and multi-cycle dmem waits with a sticky timeout.
module pipeline_hazard_ctrl
   import pipeline_hazard_ctrl_pkg::*;
#(
   parameter int MEM_TIMEOUT = 64,
   parameter int CNT_W       = 16
)(
   input  logic             clk,
   input  logic             rstN,
   input  regName_t         rs1_ID,
   input  regName_t         rs2_ID,
   input  logic             usesRs1_ID,
   input  logic             usesRs2_ID,
   input  logic             memRead_EX,
   input  regName_t         rd_EX,
   input  logic             branchTaken_EX,
   input  logic             dmemReq_MEM,
   input  logic             dmemReady_MEM,
   output logic             pcWrite,
   output logic             ifidWrite,
   output logic             ifidFlush,
   output logic             idexBubble,
   output logic             idexWrite,
   output logic             exmemWrite,
   output logic             memwbBubble,
   output logic             memErr,
   output logic [CNT_W-1:0] stallCnt
);

   localparam int                WAIT_W = $clog2(MEM_TIMEOUT + 1);
   localparam logic [WAIT_W:0]   TMO    = (WAIT_W + 1)'(MEM_TIMEOUT);

   hazard_state_t     state;
   logic [WAIT_W-1:0] wait_cnt;
   logic [WAIT_W:0]   wait_nxt;
   logic              load_use, mem_wait, run, rel, go, stall, keep_waiting, hit_tmo;

   load_use_detect u_load_use_detect (
      .memRead_EX (memRead_EX),
      .rd_EX      (rd_EX),
      .rs1_ID     (rs1_ID),
      .rs2_ID     (rs2_ID),
      .usesRs1_ID (usesRs1_ID),
      .usesRs2_ID (usesRs2_ID),
      .load_use   (load_use)
   );

   // run: normal RUN cycle; rel: dmem completes while waiting, pipeline advances unmodified
   assign mem_wait = dmemReq_MEM && !dmemReady_MEM;
   assign run      = rstN && state == RUN && !mem_wait;
   assign rel      = rstN && state == MEM_WAIT && dmemReady_MEM;
   assign go       = run || rel;
   assign stall    = run && !branchTaken_EX && load_use;

   assign pcWrite     = go && !stall;
   assign ifidWrite   = go && !stall;
   assign ifidFlush   = run && branchTaken_EX;
   assign idexBubble  = run && (branchTaken_EX || load_use);
   assign idexWrite   = go;
   assign exmemWrite  = go;
   assign memwbBubble = rstN && !go;

   // the cycle that first sees the wait counts as wait cycle 1
   assign keep_waiting = state == RUN ? mem_wait : state == MEM_WAIT && !dmemReady_MEM;
   assign wait_nxt     = state == RUN ? (WAIT_W + 1)'(1) : {1'b0, wait_cnt} + (WAIT_W + 1)'(1);
   assign hit_tmo      = wait_nxt >= TMO;

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         state    <= RUN;
         wait_cnt <= '0;
         memErr   <= 1'b0;
         stallCnt <= '0;
      end else begin
         if (!pcWrite && stallCnt != '1) stallCnt <= stallCnt + CNT_W'(1);
         if (rel) begin
            state    <= RUN;
            wait_cnt <= '0;
         end else if (keep_waiting) begin
            state    <= hit_tmo ? TIMEOUT : MEM_WAIT;
            wait_cnt <= WAIT_W'(wait_nxt);
            if (hit_tmo) memErr <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed and random checks of the hazard controller
// against a cycle-level behavioural model (MEM_TIMEOUT=4, CNT_W=2).
module tb_pipeline_hazard_ctrl;
   import pipeline_hazard_ctrl_pkg::*;

   localparam int TMO   = 4;
   localparam int CW    = 2;
   localparam int CMAX  = (1 << CW) - 1;

   logic clk = 0, rst_n = 0;
   regName_t rs1 = zero, rs2 = zero, rd = zero;
   logic u1 = 0, u2 = 0, mr = 0, br = 0, rq = 0, rdy = 0;
   logic pc_write, ifid_write, ifid_flush, idex_bubble, idex_write, exmem_write, memwb_bubble, mem_err;
   logic [CW-1:0] stall_cnt;
   wire  [6:0] ctrl = {pc_write, ifid_write, ifid_flush, idex_bubble, idex_write, exmem_write, memwb_bubble};

   localparam logic [6:0] NORMAL = 7'b1100110, BRANCH = 7'b1111110, STALL = 7'b0001110, FROZEN = 7'b0000001;

   int checks = 0, errors = 0;
   bit m_waiting, m_dead;
   int m_waited, m_stalls;

   always #5 clk = ~clk;

   pipeline_hazard_ctrl #(.MEM_TIMEOUT(TMO), .CNT_W(CW)) dut (
      .clk(clk), .rstN(rst_n), .rs1_ID(rs1), .rs2_ID(rs2), .usesRs1_ID(u1), .usesRs2_ID(u2),
      .memRead_EX(mr), .rd_EX(rd), .branchTaken_EX(br), .dmemReq_MEM(rq), .dmemReady_MEM(rdy),
      .pcWrite(pc_write), .ifidWrite(ifid_write), .ifidFlush(ifid_flush), .idexBubble(idex_bubble),
      .idexWrite(idex_write), .exmemWrite(exmem_write), .memwbBubble(memwb_bubble),
      .memErr(mem_err), .stallCnt(stall_cnt)
   );

   function automatic logic [6:0] exp_ctrl();
      bit lu;
      lu = mr && rd != zero && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
      if (!rst_n) return 7'b0;
      if (m_dead || (m_waiting && !rdy) || (!m_waiting && rq && !rdy)) return FROZEN;
      if (m_waiting) return NORMAL;
      if (br) return BRANCH;
      return lu ? STALL : NORMAL;
   endfunction

   function automatic logic [CW-1:0] exp_cnt();
      return CW'(m_stalls > CMAX ? CMAX : m_stalls);
   endfunction

   task automatic model_clear();
      m_waiting = 0; m_dead = 0; m_waited = 0; m_stalls = 0;
   endtask

   task automatic tick();
      logic [6:0] c;
      @(posedge clk);
      c = exp_ctrl();
      if (rst_n) begin
         if (!c[6]) m_stalls++;
         if (!m_dead) begin
            if (m_waiting && rdy) begin
               m_waiting = 0; m_waited = 0;
            end else if (m_waiting || (rq && !rdy)) begin
               m_waited = m_waiting ? m_waited + 1 : 1;
               m_waiting = 1;
               if (m_waited >= TMO) m_dead = 1;
            end
         end
      end
      #1;
   endtask

   task automatic set_in(input int r1, input int r2, input int d, input bit a, input bit b,
                         input bit m, input bit t, input bit q, input bit y);
      rs1 = regName_t'(r1); rs2 = regName_t'(r2); rd = regName_t'(d);
      u1 = a; u2 = b; mr = m; br = t; rq = q; rdy = y;
   endtask

   task automatic do_reset();
      set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
      #2 rst_n = 0;
      model_clear();
      @(negedge clk) rst_n = 1;
      tick();
   endtask

   task automatic test_reset();
      set_in(5, 5, 5, 1, 1, 1, 1, 1, 0);
      rst_n = 0;
      model_clear();
      #1;
      checks++;
      if (ctrl !== 7'b0) begin errors++; $display("FAIL reset_ctrl got %b want %b", ctrl, 7'b0); end
      checks++;
      if (stall_cnt !== '0 || mem_err !== 1'b0) begin
         errors++; $display("FAIL reset_regs got cnt=%0d err=%b want cnt=0 err=0", stall_cnt, mem_err);
      end
      do_reset();
   endtask

   task automatic test_load_use();
      do_reset();
      set_in(1, 5, 5, 1, 1, 1, 0, 0, 0);
      #1;
      checks++;
      if (ctrl !== STALL || ctrl !== exp_ctrl()) begin errors++; $display("FAIL load_use got %b want %b", ctrl, STALL); end
      tick();
      rd = zero;
      #1;
      checks++;
      if (ctrl !== NORMAL) begin errors++; $display("FAIL load_use_clear got %b want %b", ctrl, NORMAL); end
      checks++;
      if (stall_cnt !== 2'd1) begin errors++; $display("FAIL load_use_cnt got %0d want 1", stall_cnt); end
   endtask

   task automatic test_zero_rd();
      do_reset();
      set_in(0, 0, 0, 1, 1, 1, 0, 0, 0);
      #1;
      checks++;
      if (ctrl !== NORMAL) begin errors++; $display("FAIL zero_rd got %b want %b", ctrl, NORMAL); end
      tick();
      checks++;
      if (stall_cnt !== 2'd0) begin errors++; $display("FAIL zero_rd_cnt got %0d want 0", stall_cnt); end
   endtask

   task automatic test_branch_squash();
      do_reset();
      set_in(7, 3, 7, 1, 0, 1, 1, 0, 0);
      #1;
      checks++;
      if (ctrl !== BRANCH) begin errors++; $display("FAIL branch_squash got %b want %b", ctrl, BRANCH); end
      tick();
      checks++;
      if (stall_cnt !== 2'd0) begin errors++; $display("FAIL branch_squash_cnt got %0d want 0", stall_cnt); end
   endtask

   task automatic test_mem_wait();
      do_reset();
      set_in(0, 0, 0, 0, 0, 0, 1, 1, 0);
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++;
         if (ctrl !== FROZEN) begin errors++; $display("FAIL mem_wait_%0d got %b want %b", i, ctrl, FROZEN); end
         tick();
      end
      rdy = 1;
      #1;
      checks++;
      if (ctrl !== NORMAL) begin errors++; $display("FAIL mem_release got %b want %b", ctrl, NORMAL); end
      tick();
      rq = 0; rdy = 0;
      #1;
      checks++;
      if (ctrl !== BRANCH) begin errors++; $display("FAIL mem_held_branch got %b want %b", ctrl, BRANCH); end
      checks++;
      if (stall_cnt !== 2'd3) begin errors++; $display("FAIL mem_wait_cnt got %0d want 3", stall_cnt); end
      tick();
   endtask

   task automatic test_timeout();
      do_reset();
      set_in(0, 0, 0, 0, 0, 0, 0, 1, 0);
      for (int i = 0; i < TMO - 1; i++) tick();
      checks++;
      if (mem_err !== 1'b0) begin errors++; $display("FAIL timeout_early got %b want 0", mem_err); end
      tick();
      checks++;
      if (mem_err !== 1'b1) begin errors++; $display("FAIL timeout_err got %b want 1", mem_err); end
      rdy = 1;
      #1;
      checks++;
      if (ctrl !== FROZEN) begin errors++; $display("FAIL timeout_frozen got %b want %b", ctrl, FROZEN); end
      tick();
      tick();
      checks++;
      if (mem_err !== 1'b1 || ctrl !== FROZEN) begin
         errors++; $display("FAIL timeout_sticky got err=%b ctrl=%b want err=1 ctrl=%b", mem_err, ctrl, FROZEN);
      end
      do_reset();
      checks++;
      if (mem_err !== 1'b0 || ctrl !== NORMAL) begin
         errors++; $display("FAIL timeout_cleared got err=%b ctrl=%b want err=0 ctrl=%b", mem_err, ctrl, NORMAL);
      end
   endtask

   task automatic test_reset_mid_wait();
      do_reset();
      set_in(0, 0, 0, 0, 0, 0, 0, 1, 0);
      tick();
      tick();
      checks++;
      if (stall_cnt !== 2'd2) begin errors++; $display("FAIL mid_wait_cnt got %0d want 2", stall_cnt); end
      #2 rst_n = 0;
      model_clear();
      #1;
      checks++;
      if (ctrl !== 7'b0 || stall_cnt !== '0 || mem_err !== 1'b0) begin
         errors++; $display("FAIL mid_wait_reset got ctrl=%b cnt=%0d err=%b want all 0", ctrl, stall_cnt, mem_err);
      end
      rq = 0;
      @(negedge clk) rst_n = 1;
      tick();
      #1;
      checks++;
      if (ctrl !== NORMAL) begin errors++; $display("FAIL mid_wait_run got %b want %b", ctrl, NORMAL); end
   endtask

   task automatic test_saturation();
      do_reset();
      set_in(9, 0, 9, 1, 0, 1, 0, 0, 0);
      for (int i = 0; i < 5; i++) tick();
      checks++;
      if (stall_cnt !== 2'd3) begin errors++; $display("FAIL saturation got %0d want 3", stall_cnt); end
   endtask

   task automatic test_random();
      do_reset();
      for (int i = 0; i < 600; i++) begin
         if (m_dead && $urandom_range(0, 4) == 0) do_reset();
         set_in($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
                $urandom_range(0, 4) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 4) < 3);
         #1;
         checks++;
         if (ctrl !== exp_ctrl()) begin errors++; $display("FAIL rand_ctrl[%0d] got %b want %b", i, ctrl, exp_ctrl()); end
         tick();
         checks++;
         if (stall_cnt !== exp_cnt() || mem_err !== m_dead) begin
            errors++; $display("FAIL rand_regs[%0d] got cnt=%0d err=%b want cnt=%0d err=%b", i, stall_cnt, mem_err, exp_cnt(), m_dead);
         end
      end
   endtask

   initial begin
      model_clear();
      #1;
      test_reset();
      test_load_use();
      test_zero_rd();
      test_branch_squash();
      test_mem_wait();
      test_timeout();
      test_reset_mid_wait();
      test_saturation();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
